// File: rtl/channel_voice_pkg.sv
// Shared definitions for the channel voice: waveform select codes and PWM frame geometry.
package channel_voice_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_RSV    = 2'd3
    } wave_e;

    localparam int         FRAME_LEN = 256;
    localparam logic [7:0] CNT_LAST  = 8'(FRAME_LEN - 1);

endpackage

// File: rtl/channel_voice_waveform.sv
// Maps an 8-bit phase index and a waveform select to an 8-bit unsigned wave value.
module voice_waveform
    import channel_voice_pkg::*;
(
    input  logic [7:0] i_p,
    input  logic [1:0] i_wave,
    output logic [7:0] o_wave
);

    always_comb begin
        o_wave = 8'h00;
        case (i_wave)
            WAVE_SQUARE: o_wave = i_p[7] ? 8'hFF : 8'h00;
            WAVE_SAW:    o_wave = i_p;
            // Rising over the first half of the cycle, mirrored over the second half.
            WAVE_TRI:    o_wave = i_p[7] ? ~{i_p[6:0], 1'b0} : {i_p[6:0], 1'b0};
            default:     o_wave = 8'h00;
        endcase
    end

endmodule

// File: rtl/channel_voice.sv
// One sound channel: DDS phase accumulator, waveform lookup, amplitude scaling and 8-bit PWM output.
module channel_voice
    import channel_voice_pkg::*;
#(
    parameter int         PHASE_W   = 32,
    parameter logic [7:0] AMP_RESET = 8'hFF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PHASE_W-1:0] i_phase_delta,
    input  logic [7:0]         i_top,
    input  logic               i_top_valid,
    input  logic [1:0]         i_wave,
    output logic [7:0]         o_sample,
    output logic               o_sample_valid,
    output logic               o_pwm
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_prev_delta;
    logic [7:0]         r_amp;
    logic [7:0]         r_scaled;
    logic [7:0]         r_cnt;
    logic [7:0]         r_duty;
    logic               r_sample_valid;
    logic               r_pwm;

    logic [7:0]         w_wave;
    logic [15:0]        w_product;
    logic [7:0]         w_cnt_next;
    logic [7:0]         w_duty_next;
    logic               w_frame_end;

    voice_waveform u_waveform (
        .i_p    (r_phase[PHASE_W-1 -: 8]),
        .i_wave (i_wave),
        .o_wave (w_wave)
    );

    assign w_product   = {8'h00, w_wave} * {8'h00, r_amp};
    assign w_frame_end = (r_cnt == CNT_LAST);
    assign w_cnt_next  = r_cnt + 8'd1;
    // Duty is only ever refreshed at the frame boundary so a running frame is never disturbed.
    assign w_duty_next = w_frame_end ? r_scaled : r_duty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase        <= '0;
            r_prev_delta   <= '0;
            r_amp          <= AMP_RESET;
            r_scaled       <= 8'h00;
            r_cnt          <= 8'h00;
            r_duty         <= 8'h00;
            r_sample_valid <= 1'b0;
            r_pwm          <= 1'b0;
        end else begin
            r_prev_delta <= i_phase_delta;
            // A rest or a new note restarts the waveform from phase zero.
            if (i_phase_delta == '0 || i_phase_delta != r_prev_delta) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + i_phase_delta;
            end
            if (i_top_valid) begin
                r_amp <= i_top;
            end
            r_scaled       <= w_product[15:8];
            r_cnt          <= w_cnt_next;
            r_duty         <= w_duty_next;
            r_sample_valid <= w_frame_end;
            // Registered compare against next-state values keeps o_pwm glitch-free and equal to cnt < duty.
            r_pwm          <= (w_cnt_next < w_duty_next);
        end
    end

    assign o_sample       = r_duty;
    assign o_sample_valid = r_sample_valid;
    assign o_pwm          = r_pwm;

endmodule

// File: tb/tb_channel_voice.sv
// Self-checking bench for channel_voice: frame vectors, hand-written corner sequences and a randomized model run.
module tb_channel_voice;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] delta;
    logic [7:0]  top;
    logic        top_valid;
    logic [1:0]  wave;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        pwm;

    int n_vec = 0;
    int n_err = 0;

    channel_voice dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_phase_delta  (delta),
        .i_top          (top),
        .i_top_valid    (top_valid),
        .i_wave         (wave),
        .o_sample       (sample),
        .o_sample_valid (sample_valid),
        .o_pwm          (pwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wave;
        logic [31:0] delta;
        logic [7:0]  amp;
        logic [7:0]  exp_sample;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk("reset_outputs", {sample, sample_valid, pwm}, 32'd0);
        end
    endtask

    // Reference model: plain arithmetic on the behavioural rules.
    logic [31:0] m_phase, m_prev;
    int          m_amp, m_scaled, m_cnt, m_duty;
    bit          m_valid;

    function automatic int wave_of(input int p, input logic [1:0] w);
        case (w)
            2'd0: return (p >= 128) ? 255 : 0;
            2'd1: return p;
            2'd2: return (p < 128) ? 2 * p : 511 - 2 * p;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit r, input logic [31:0] d, input logic [7:0] t,
                              input bit tv, input logic [1:0] w);
        int new_scaled;
        if (r) begin
            m_phase = 0; m_prev = 0; m_amp = 255; m_scaled = 0;
            m_cnt = 0; m_duty = 0; m_valid = 0;
        end else begin
            new_scaled = (wave_of(int'(m_phase >> 24), w) * m_amp) / 256;
            m_valid = (m_cnt == 255);
            if (m_cnt == 255) m_duty = m_scaled;
            m_cnt = (m_cnt + 1) % 256;
            m_scaled = new_scaled;
            if (tv) m_amp = int'(t);
            m_phase = (d == 0 || d != m_prev) ? 32'd0 : m_phase + d;
            m_prev = d;
        end
    endtask

    initial begin
        int early, hi;
        vecs[0] = '{2'd1, 32'h0100_0000, 8'hFF, 8'd252};
        vecs[1] = '{2'd0, 32'h0000_0000, 8'hFF, 8'd0};
        vecs[2] = '{2'd3, 32'h0100_0000, 8'hFF, 8'd0};
        vecs[3] = '{2'd0, 32'h0100_0000, 8'hFF, 8'd254};
        vecs[4] = '{2'd1, 32'h0100_0000, 8'h80, 8'd126};
        vecs[5] = '{2'd2, 32'h0100_0000, 8'hFF, 8'd4};
        vecs[6] = '{2'd1, 32'h0200_0000, 8'hFF, 8'd249};
        vecs[7] = '{2'd2, 32'h0200_0000, 8'h80, 8'd5};

        rst = 1'b1; delta = '0; top = 8'hFF; top_valid = 1'b0; wave = 2'd0;
        tick();

        // Frame vectors: each starts from a reset applied wherever the previous one stopped.
        foreach (vecs[v]) begin
            top = vecs[v].amp; top_valid = 1'b1;
            do_reset(3);
            rst = 1'b0; delta = vecs[v].delta; wave = vecs[v].wave;
            early = 0;
            for (int n = 1; n <= 256; n++) begin
                tick();
                if (n < 256 && sample_valid) early++;
            end
            chk("no_early_valid", early, 0);
            chk("first_valid_256", sample_valid, 1'b1);
            chk("frame1_sample", sample, vecs[v].exp_sample);
            hi = 0;
            for (int k = 0; k < 256; k++) begin
                hi += int'(pwm);
                tick();
            end
            chk("frame1_pwm_high", hi, int'(vecs[v].exp_sample));
            chk("frame2_valid", sample_valid, 1'b1);
            chk("frame2_sample", sample, vecs[v].exp_sample);
            for (int k = 0; k < 100; k++) tick();
        end
        top_valid = 1'b0;

        // Amplitude drops to zero mid-frame; the running frame keeps its duty.
        do_reset(3);
        rst = 1'b0; delta = 32'h0100_0000; wave = 2'd1; top = 8'hFF;
        for (int n = 1; n <= 256; n++) tick();
        hi = 0;
        for (int n = 256; n < 512; n++) begin
            hi += int'(pwm);
            if (n == 356) begin top = 8'h00; top_valid = 1'b1; end
            if (n == 357) begin top = 8'hFF; top_valid = 1'b0; end
            tick();
        end
        chk("amp_frame_kept_pwm", hi, 252);
        chk("amp_zero_valid", sample_valid, 1'b1);
        chk("amp_zero_sample", sample, 8'd0);
        hi = 0;
        for (int n = 512; n < 768; n++) begin
            hi += int'(pwm);
            tick();
        end
        chk("amp_ignored_sample", sample, 8'd0);
        chk("amp_ignored_pwm", hi, 0);

        // Retrigger on note change.
        do_reset(3);
        rst = 1'b0; delta = 32'h0100_0000; wave = 2'd1; top = 8'hFF;
        for (int n = 1; n <= 300; n++) tick();
        chk("phase_before_retrig", dut.r_phase, 32'(43) << 24);
        delta = 32'h0200_0000;
        tick();
        chk("retrig_phase0", dut.r_phase, 32'h0);
        tick();
        chk("retrig_phase1", dut.r_phase, 32'h0200_0000);
        tick();
        chk("retrig_phase2", dut.r_phase, 32'h0400_0000);
        chk("retrig_frame_kept", sample, 8'd252);

        // Randomized run against the reference model.
        rst = 1'b1;
        model_step(1'b1, delta, top, top_valid, wave);
        tick();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(499) == 0);
            if ($urandom_range(299) == 0) begin
                case ($urandom_range(3))
                    0: delta = 32'h0;
                    1: delta = 32'h0100_0000;
                    2: delta = 32'h0200_0000;
                    default: delta = $urandom;
                endcase
            end
            if ($urandom_range(399) == 0) wave = 2'($urandom_range(3));
            top_valid = ($urandom_range(49) == 0);
            top = 8'($urandom_range(255));
            model_step(rst, delta, top, top_valid, wave);
            tick();
            chk("rand_cycle", {sample, sample_valid, pwm},
                {8'(m_duty), m_valid, 1'(m_cnt < m_duty)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
